// File: rtl/setup_move_player.sv
// Plays a per-index move list from a synchronous move ROM to the motor driver, then settles and flags the cube stable.
// Optional motor_done watchdog and motor_fault output are enabled by defining SETUP_MOVE_TIMEOUT_EN.
module setup_move_player #(
  parameter int MAX_MOVES      = 16,
  parameter int SETTLE_CYCLES  = 1500000
`ifdef SETUP_MOVE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 50000000
`endif
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               send_setup_moves,
  input  logic [5:0]                         counter,
  output logic [5+$clog2(MAX_MOVES):0]       rom_addr,
  input  logic [5:0]                         rom_data,
  output logic                               move_valid,
  output logic [4:0]                         move_code,
  input  logic                               move_ready,
  input  logic                               motor_done,
  output logic                               color_sensor_stable,
  output logic                               busy,
  output logic                               seq_overflow,
  output logic                               req_dropped,
`ifdef SETUP_MOVE_TIMEOUT_EN
  output logic                               motor_fault,
`endif
  output logic [2:0]                         dbg_state
);

  localparam int SW = $clog2(MAX_MOVES);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST   = SW'(MAX_MOVES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_DONE, S_SETTLE, S_STABLE
  } state_e;

  // Handshake: a move transfers on any clock edge where move_valid && move_ready;
  // move_valid/move_code are held unchanged until that edge.
  state_e          state_q;
  logic [5:0]      index_q;
  logic [SW-1:0]   step_q;
  logic            last_q;
  logic [CW-1:0]   settle_q;
  logic            move_valid_q;
  logic [4:0]      move_code_q;
  logic            stable_q;
  logic            ovf_q;
  logic            drop_q;
  logic            idle_like;
  logic            start_ok;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_STABLE);

`ifdef SETUP_MOVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_q;
  logic          fault_q;
  logic          in_move;
  logic          wd_expired;
  assign in_move    = (state_q == S_ISSUE) || (state_q == S_WAIT_DONE);
  assign wd_expired = (wd_q == TW'(TIMEOUT_CYCLES - 1));
  assign start_ok   = send_setup_moves & ~fault_q;
  assign motor_fault = fault_q;
`else
  assign start_ok   = send_setup_moves;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      step_q       <= '0;
      last_q       <= 1'b0;
      settle_q     <= '0;
      move_valid_q <= 1'b0;
      move_code_q  <= '0;
      stable_q     <= 1'b0;
      ovf_q        <= 1'b0;
      drop_q       <= 1'b0;
`ifdef SETUP_MOVE_TIMEOUT_EN
      wd_q         <= '0;
      fault_q      <= 1'b0;
`endif
    end else begin
      if (send_setup_moves && !idle_like) drop_q <= 1'b1;
      case (state_q)
        S_IDLE, S_STABLE: begin
          if (start_ok) begin
            index_q  <= counter;
            step_q   <= '0;
            stable_q <= 1'b0;
            state_q  <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          // A zero turn ends the list, including an empty list at step 0.
          if (rom_data[1:0] == 2'd0) begin
            settle_q <= SETTLE_LOAD;
            state_q  <= S_SETTLE;
          end else begin
            move_code_q  <= rom_data[4:0];
            last_q       <= rom_data[5];
            move_valid_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (move_ready) begin
            move_valid_q <= 1'b0;
            state_q      <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (motor_done) begin
            if (last_q) begin
              settle_q <= SETTLE_LOAD;
              state_q  <= S_SETTLE;
            end else if (step_q == STEP_LAST) begin
              ovf_q    <= 1'b1;
              settle_q <= SETTLE_LOAD;
              state_q  <= S_SETTLE;
            end else begin
              step_q  <= step_q + 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        S_SETTLE: begin
          if (settle_q == '0) begin
            stable_q <= 1'b1;
            state_q  <= S_STABLE;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef SETUP_MOVE_TIMEOUT_EN
      // Watchdog restarts for every move; a finishing motor_done wins a tie.
      if (in_move) begin
        wd_q <= wd_q + 1'b1;
        if (wd_expired && !(state_q == S_WAIT_DONE && motor_done)) begin
          move_valid_q <= 1'b0;
          fault_q      <= 1'b1;
          state_q      <= S_IDLE;
        end
      end else begin
        wd_q <= '0;
      end
`endif
    end
  end

  assign rom_addr            = {index_q, step_q};
  assign move_valid          = move_valid_q;
  assign move_code           = move_code_q;
  // Masked with the request so the scanner never sees a stale stable in the pulse cycle.
  assign color_sensor_stable = stable_q & ~send_setup_moves;
  assign busy                = ~idle_like;
  assign seq_overflow        = ovf_q;
  assign req_dropped         = drop_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_setup_move_player.sv
// Randomised bench for setup_move_player: ROM + motor model, move scoreboard, settle-latency checks.
`timescale 1ns/1ps
module tb_setup_move_player;
  localparam int MAXM   = 16;
  localparam int SETTLE = 4;
`ifdef SETUP_MOVE_TIMEOUT_EN
  localparam int TMO    = 100;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       send_setup_moves = 1'b0;
  logic [5:0] counter = '0;
  logic [9:0] rom_addr;
  logic [5:0] rom_data = '0;
  logic       move_valid;
  logic [4:0] move_code;
  logic       move_ready = 1'b0;
  logic       motor_done = 1'b0;
  logic       color_sensor_stable, busy, seq_overflow, req_dropped;
  logic [2:0] dbg_state;
`ifdef SETUP_MOVE_TIMEOUT_EN
  logic       motor_fault;
`endif

  setup_move_player #(
    .MAX_MOVES(MAXM), .SETTLE_CYCLES(SETTLE)
`ifdef SETUP_MOVE_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clock(clock), .reset(reset), .send_setup_moves(send_setup_moves), .counter(counter),
    .rom_addr(rom_addr), .rom_data(rom_data), .move_valid(move_valid), .move_code(move_code),
    .move_ready(move_ready), .motor_done(motor_done), .color_sensor_stable(color_sensor_stable),
    .busy(busy), .seq_overflow(seq_overflow), .req_dropped(req_dropped),
`ifdef SETUP_MOVE_TIMEOUT_EN
    .motor_fault(motor_fault),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // synchronous move ROM, one-cycle latency
  logic [5:0] rom [0:1023];
  always @(posedge clock) rom_data <= rom[rom_addr];

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];
  bit exp_ovf = 0, exp_drop = 0, exp_stable = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // motor driver model + monitor
  int ready_mode = 0;     // 0: always ready, 1: random, 2: hold low 20 cycles
  int done_delay = 10;    // 0: random 1..12
  int accept_cnt = 0, last_accept_cyc = 0, last_done_cyc = 0;
  bit done_pending = 0;
  int done_at = 0;
  int valid_wait = 0;
  bit prev_hold = 0;
  logic [4:0] prev_code = '0;

  initial begin
    forever begin
      @(posedge clock); #1;
      motor_done = 1'b0;
      if (done_pending && cyc == done_at) begin
        motor_done = 1'b1; done_pending = 0; last_done_cyc = cyc;
      end
      case (ready_mode)
        0:       move_ready = 1'b1;
        1:       move_ready = 1'($urandom_range(0, 1));
        default: move_ready = (valid_wait >= 20);
      endcase
      @(negedge clock);
      if (!reset) begin
        prev_hold = 0; done_pending = 0; valid_wait = 0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", move_valid, 1);
          check("hold_code", move_code, prev_code);
        end
        if (move_valid && move_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_move: got 0x%0h expected no move (cycle %0d)", move_code, cyc);
          end else begin
            check("move_code", move_code, exp_q.pop_front());
          end
          accept_cnt++;
          last_accept_cyc = cyc;
          done_pending = 1;
          done_at = cyc + ((done_delay == 0) ? $urandom_range(1, 12) : done_delay);
          valid_wait = 0;
        end else if (move_valid) begin
          valid_wait++;
        end else begin
          valid_wait = 0;
        end
        prev_hold = move_valid && !move_ready;
        prev_code = move_code;
      end
    end
  end

  function automatic logic [5:0] rand_word();
    logic [2:0] f;
    logic [1:0] t;
    logic       l;
    f = 3'($urandom_range(0, 5));
    t = ($urandom_range(0, 15) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
    l = ($urandom_range(0, 3) == 0);
    return {l, f, t};
  endfunction

  // driver: one request, model from the move-list rules, then latency checks
  task automatic run_seq(input logic [5:0] idx, input bit drop);
    int n_moves, pulse_cyc, acc0, rise, exp_rise;
    bit ovf, zero_end, seen, dropped;
    logic [5:0] w;
    n_moves = 0; ovf = 0; zero_end = 0; rise = 0;
    for (int s = 0; s < MAXM; s++) begin
      w = rom[int'(idx) * MAXM + s];
      if (w[1:0] == 2'd0) begin zero_end = 1; break; end
      exp_q.push_back(w[4:0]);
      n_moves++;
      if (w[5]) break;
      if (s == MAXM - 1) ovf = 1;
    end
    @(posedge clock); #1;
    check("stable_before_pulse", color_sensor_stable, exp_stable);
    send_setup_moves = 1'b1; counter = idx; pulse_cyc = cyc; acc0 = accept_cnt;
    @(negedge clock);
    check("stable_on_pulse", color_sensor_stable, 0);
    seen = 0; dropped = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clock); #1;
      send_setup_moves = 1'b0;
      counter = 6'($urandom_range(0, 63));
      if (drop && !dropped && accept_cnt > acc0 && cyc == last_accept_cyc + 2) begin
        send_setup_moves = 1'b1; dropped = 1;
      end
      @(negedge clock);
      if (c == 0) check("busy_after_pulse", busy, 1);
      if (color_sensor_stable) begin seen = 1; rise = cyc; break; end
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL stable_timeout: stable never rose for index %0d", idx);
    end else begin
      if (n_moves == 0) exp_rise = pulse_cyc + SETTLE + 3;
      else if (zero_end) exp_rise = last_done_cyc + SETTLE + 3;
      else exp_rise = last_done_cyc + SETTLE + 1;
      check("stable_latency", rise, exp_rise);
    end
    check("move_count", accept_cnt - acc0, n_moves);
    check("exp_q_drained", exp_q.size(), 0);
    exp_q.delete();
    if (ovf) exp_ovf = 1;
    if (dropped) exp_drop = 1;
    exp_stable = seen;
    check("seq_overflow", seq_overflow, exp_ovf);
    check("req_dropped", req_dropped, exp_drop);
    check("busy_when_stable", busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    logic [5:0] idx;
    bit found;
    for (int i = 0; i < 1024; i++) rom[i] = 6'($urandom_range(0, 63));
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_move_valid", move_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_stable", color_sensor_stable, 0);
    check("rst_ovf", seq_overflow, 0);
    check("rst_drop", req_dropped, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_move_code", move_code, 0);
`ifdef SETUP_MOVE_TIMEOUT_EN
    check("rst_fault", motor_fault, 0);
`endif
    @(posedge clock); #1 reset = 1'b1;

    // F CW then B CCW(last) at index 5
    rom[5*MAXM + 0] = 6'h09; rom[5*MAXM + 1] = 6'h33;
    ready_mode = 0; done_delay = 10;
    run_seq(6'd5, 0);
    // empty sequence
    rom[0] = 6'h00;
    run_seq(6'd0, 0);
    // ready held low for 20 cycles
    rom[9*MAXM] = 6'h2a;
    ready_mode = 2;
    run_seq(6'd9, 0);
    // request while waiting on motor_done
    rom[20*MAXM] = 6'h07; rom[20*MAXM + 1] = 6'h35;
    ready_mode = 0; done_delay = 10;
    run_seq(6'd20, 1);
    // sixteen moves with no last bit
    for (int s = 0; s < MAXM; s++)
      rom[7*MAXM + s] = {1'b0, 3'($urandom_range(0, 5)), 2'($urandom_range(1, 3))};
    ready_mode = 1; done_delay = 0;
    run_seq(6'd7, 0);
    // random lists, including indices 52..63
    for (int k = 0; k < 12; k++) begin
      idx = (k % 3 == 0) ? 6'($urandom_range(52, 63)) : 6'($urandom_range(0, 63));
      for (int s = 0; s < MAXM; s++) rom[int'(idx) * MAXM + s] = rand_word();
      ready_mode = $urandom_range(0, 1); done_delay = 0;
      run_seq(idx, 0);
    end

    // reset while a move is presented
    rom[33*MAXM] = 6'h25;
    ready_mode = 2;
    @(posedge clock); #1;
    send_setup_moves = 1'b1; counter = 6'd33;
    @(posedge clock); #1 send_setup_moves = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (move_valid) begin found = 1; break; end
    end
    check("valid_before_reset", found, 1);
    reset = 1'b0;
    #1;
    check("async_valid_drop", move_valid, 0);
    check("async_busy", busy, 0);
    check("async_ovf", seq_overflow, 0);
    check("async_drop", req_dropped, 0);
    check("async_stable", color_sensor_stable, 0);
    exp_q.delete(); exp_ovf = 0; exp_drop = 0; exp_stable = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    ready_mode = 0; done_delay = 0;
    run_seq(6'd5, 0);

`ifdef SETUP_MOVE_TIMEOUT_EN
    begin
      int v, fr;
      bit fseen;
      rom[40*MAXM] = 6'h21;
      ready_mode = 0; done_delay = 1000000;
      exp_q.push_back(5'h01);
      @(posedge clock); #1;
      send_setup_moves = 1'b1; counter = 6'd40;
      @(posedge clock); #1 send_setup_moves = 1'b0;
      v = 0; fr = 0; fseen = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clock);
        if (move_valid) begin v = cyc; break; end
      end
      for (int c = 0; c < 300; c++) begin
        @(negedge clock);
        if (motor_fault) begin fseen = 1; fr = cyc; break; end
      end
      check("fault_seen", fseen, 1);
      check("fault_cycle", fr, v + TMO);
      check("fault_valid", move_valid, 0);
      check("fault_stable", color_sensor_stable, 0);
      @(posedge clock); #1 send_setup_moves = 1'b1; counter = 6'd5;
      @(posedge clock); #1 send_setup_moves = 1'b0;
      @(negedge clock);
      check("fault_ignores_req", busy, 0);
      reset = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
    end
`endif

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/setup_move_player.md
Name: setup_move_player

Overview:
- Responder side of the scan-sequencer handshake.
- When it sees a one-cycle send_setup_moves pulse, it captures the 6-bit sequence index (counter) from the scanning FSM.
- It reads that index's move list from an external move ROM and issues the moves one at a time to the motor driver.
- It then waits a mechanical/optical settle time and raises color_sensor_stable, so the scanning FSM can sample the colour sensors.

Parameters:
- MAX_MOVES, 16, maximum moves per sequence; must be a power of 2; sets step counter width log2(MAX_MOVES).
- SETTLE_CYCLES, 1500000, clock cycles from last motor_done (or from an empty sequence) to color_sensor_stable; must be >= 1.
- TIMEOUT_CYCLES, 50000000, motor_done watchdog limit; used only with SETUP_MOVE_TIMEOUT_EN.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- send_setup_moves  in  1  one-cycle request pulse from the scanning FSM.
- counter  in  6  sequence index; sampled in the same cycle as send_setup_moves.
- rom_addr  out  6+log2(MAX_MOVES)  {latched index, step}.
- rom_data  in  6  move word: [5] last, [4:2] face (U=0,L=1,F=2,R=3,B=4,D=5), [1:0] turn (0=none, 1=CW, 2=half, 3=CCW); synchronous ROM, 1-cycle read latency.
- move_valid  out  1  move_code valid for the motor driver.
- move_code  out  5  {face, turn}.
- move_ready  in  1  motor driver accepts move_code.
- motor_done  in  1  one-cycle pulse when the accepted move has finished.
- color_sensor_stable  out  1  level; cube is still and sensors are valid.
- busy  out  1  a sequence is in progress (any state other than IDLE/STABLE).
- seq_overflow  out  1  sticky; a sequence reached MAX_MOVES without its last bit.
- req_dropped  out  1  sticky; a request arrived while busy.

Behaviour:
- Reset (async, reset low): state=IDLE, all outputs 0, index/step/settle counters 0, sticky flags cleared.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, SETTLE, STABLE.
- IDLE/STABLE + send_setup_moves:
  - Latch counter, step<=0, go to FETCH.
  - color_sensor_stable must read 0 in the same cycle as the pulse. The output is a registered stable flag ANDed combinationally with ~send_setup_moves.
  - Reason: the scanning FSM tests stable in the cycle after it raises the pulse.
- FETCH: drive rom_addr={index,step}; go to DECODE (1-cycle ROM latency).
- DECODE:
  - turn==0: the sequence ends. Go to SETTLE, load settle counter with SETTLE_CYCLES-1. This covers empty sequences, which still settle.
  - Otherwise: register move_code, move_valid<=1, go to ISSUE.
- ISSUE: hold move_valid/move_code stable until move_ready=1. On that cycle, move_valid<=0 and go to WAIT_DONE.
- WAIT_DONE, on motor_done:
  - last=1 -> SETTLE.
  - step==MAX_MOVES-1 -> set seq_overflow, SETTLE.
  - otherwise step<=step+1, FETCH.
- SETTLE:
  - Decrement each cycle.
  - At 0, the stable register <=1 and state -> STABLE.
  - Latency from the motor_done cycle to stable high is SETTLE_CYCLES+1 cycles.
- STABLE: hold stable until the next send_setup_moves. The stable register clears on the pulse.
- send_setup_moves in any busy state: ignored, set req_dropped; the current sequence continues unchanged.
- A motor_done pulse outside WAIT_DONE is ignored.
- Reset mid-sequence: immediate return to IDLE, move_valid drops asynchronously. The motor driver must tolerate an abandoned move.
- counter values 52–63 are legal; their content is defined by the ROM.

Optional Feature:
- Macro SETUP_MOVE_TIMEOUT_EN.
- Defined:
  - Add output motor_fault (1 bit, sticky, reset 0).
  - A watchdog counts cycles in ISSUE+WAIT_DONE per move.
  - At TIMEOUT_CYCLES: drop move_valid, set motor_fault, go to IDLE. color_sensor_stable stays 0 and new requests are ignored until reset.
- Undefined: no watchdog, no motor_fault port. The block waits indefinitely.

Test Plan:
- Index 5, ROM = {F CW}, {B CCW, last}; move_ready tied 1; motor_done 10 cycles after accept; SETTLE_CYCLES=4 -> move_codes 0x09 then 0x13 in order. color_sensor_stable rises exactly 5 cycles after the second motor_done. rom_addr takes values {5,0} then {5,1}.
- Empty sequence (index 0, word 0x00) -> no move_valid; stable rises SETTLE_CYCLES+3 cycles after the pulse.
- move_ready held low 20 cycles -> move_valid and move_code stay constant the whole time; exactly one accept.
- Pulse while in WAIT_DONE -> req_dropped=1; sequence completes normally. Pulse in STABLE -> color_sensor_stable=0 in the same cycle.
- All 16 words with last=0 -> 16 moves issued, seq_overflow=1, then settle and stable.
- Reset low during ISSUE -> move_valid=0 immediately, all flags 0. With SETUP_MOVE_TIMEOUT_EN, TIMEOUT_CYCLES=100 and no motor_done -> motor_fault=1 at cycle 100.
